// File: rtl/bcd_timer_pkg.sv
// Shared types, widths and the packed-BCD increment helper for the stopwatch controller.
package bcd_timer_pkg;

  localparam int BCD_W   = 16;
  localparam int NDIGITS = 4;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_CLEAR = 2'd2,
    CMD_LAP   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DONE  = 3'd3,
    S_CLR   = 3'd4
  } state_e;

  // Ripple a +1 through the digits; 9 rolls to 0 and carries, so 9999 wraps to 0000.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_counter.sv
// Four-digit packed-BCD counter with synchronous clear and increment strobe.
module bcd4_counter
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] count,
  output logic [BCD_W-1:0] count_next
);

  assign count_next = bcd_inc(count);

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (clr) begin
      count <= 16'h0000;
    end else if (inc) begin
      count <= count_next;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Stopwatch/timer sequencer: command handshake, clock prescaler, BCD limit compare, lap capture.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter  int PRESCALE = 1000,
  localparam int PS_W     = $clog2(PRESCALE + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        limit_en,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic [15:0] lap,
  output logic        lap_valid,
  output logic        running,
  output logic        done,
  output logic        tick
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_e           state_r, state_next_s;
  logic [PS_W-1:0]  ps_r, ps_next_s;
  logic [15:0]      lap_r;
  logic             lap_valid_r;
  logic [15:0]      count_s, count_next_s;
  cmd_op_e          op_s;
  logic             accept_s, start_s, stop_s, clear_s, lap_s;
  logic             tick_s, hit_s, cnt_clr_s, cnt_inc_s;

  assign op_s      = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_r != S_CLR);
  assign accept_s  = cmd_valid && cmd_ready;
  assign start_s   = accept_s && (op_s == CMD_START);
  assign stop_s    = accept_s && (op_s == CMD_STOP);
  assign clear_s   = accept_s && (op_s == CMD_CLEAR);
  assign lap_s     = accept_s && (op_s == CMD_LAP);

  assign tick_s    = (state_r == S_RUN) && (ps_r == PS_LAST);
  // Next value is always valid BCD, so a limit with a nibble above 9 can never match.
  assign hit_s     = limit_en && (count_next_s == limit);
  assign cnt_clr_s = (state_r == S_CLR);
  assign cnt_inc_s = tick_s && !clear_s;

  bcd4_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr_s),
    .inc        (cnt_inc_s),
    .count      (count_s),
    .count_next (count_next_s)
  );

  // Next-state and prescaler logic; CLEAR outranks a coincident tick.
  always_comb begin
    state_next_s = state_r;
    ps_next_s    = ps_r;
    case (state_r)
      S_IDLE: begin
        if (clear_s)      state_next_s = S_CLR;
        else if (start_s) state_next_s = S_RUN;
        else              state_next_s = S_IDLE;
      end
      S_RUN: begin
        if (clear_s) begin
          state_next_s = S_CLR;
        end else if (tick_s) begin
          ps_next_s = {PS_W{1'b0}};
          if (hit_s)       state_next_s = S_DONE;
          else if (stop_s) state_next_s = S_PAUSE;
          else             state_next_s = S_RUN;
        end else if (stop_s) begin
          state_next_s = S_PAUSE;
        end else begin
          ps_next_s = ps_r + PS_W'(1);
        end
      end
      S_PAUSE: begin
        if (clear_s)      state_next_s = S_CLR;
        else if (start_s) state_next_s = S_RUN;
        else              state_next_s = S_PAUSE;
      end
      S_DONE: begin
        if (clear_s) state_next_s = S_CLR;
        else         state_next_s = S_DONE;
      end
      S_CLR: begin
        state_next_s = S_IDLE;
        ps_next_s    = {PS_W{1'b0}};
      end
      default: begin
        state_next_s = S_IDLE;
        ps_next_s    = {PS_W{1'b0}};
      end
    endcase
  end

  // State, prescaler and lap snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      ps_r        <= {PS_W{1'b0}};
      lap_r       <= 16'h0000;
      lap_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      ps_r        <= ps_next_s;
      lap_valid_r <= lap_s;
      if (lap_s) lap_r <= count_s;
      else       lap_r <= lap_r;
    end
  end

  assign count     = count_s;
  assign lap       = lap_r;
  assign lap_valid = lap_valid_r;
  assign running   = (state_r == S_RUN);
  assign done      = (state_r == S_DONE);
  assign tick      = tick_s;

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
Controller that sequences a 4-digit packed-BCD counter as a stopwatch/timer. It takes START/STOP/CLEAR/LAP commands over a valid/ready handshake and prescales the clock into count ticks. It also compares the count against an optional BCD limit and captures lap snapshots. It sits between a software/UI command source and display logic.

Parameters:
PRESCALE, 1000, clk cycles per count tick; legal range 1..65535.
PS_W, $clog2(PRESCALE+1), prescaler counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  2  0=START, 1=STOP, 2=CLEAR, 3=LAP
limit_en  input  1  enable limit compare
limit  input  16  BCD limit value, 4 digits
count  output  16  current BCD count
lap  output  16  last lap snapshot
lap_valid  output  1  one-cycle pulse, the cycle after a LAP is accepted
running  output  1  high in RUN
done  output  1  high in DONE
tick  output  1  one-cycle count-advance strobe

Behaviour:
- Reset: clk and reset are one clock domain; rst_n asserts asynchronously.
  - Reset values: state=IDLE, count=0x0000, lap=0x0000, prescaler=0, lap_valid=0, running=0, done=0, tick=0, cmd_ready=1.
  - Reset mid-run aborts immediately; no command is pending after release.
- cmd_ready=1 in every state except CLR. An accepted command takes effect at that edge.
- States:
  - IDLE: START→RUN. CLEAR→CLR. STOP is ignored (still handshaken).
  - RUN: STOP→PAUSE; the prescaler holds its value. CLEAR→CLR. START is ignored.
  - PAUSE: START→RUN; the prescaler resumes from its held value. CLEAR→CLR. STOP is ignored.
  - DONE: count is frozen. CLEAR→CLR. START and STOP are ignored.
  - CLR: lasts one cycle. count←0, prescaler←0, done←0; lap is unchanged. Next state is IDLE.
- LAP is legal in every state except CLR (where it cannot be accepted). It sets lap←count (the register value in the accept cycle) and pulses lap_valid in the following cycle.
- Prescaler:
  - Counts only in RUN, 0..PRESCALE-1.
  - tick = (state==RUN) && (prescaler==PRESCALE-1), combinational. Prescaler wraps to 0 on tick.
  - With PRESCALE=1, tick is high every RUN cycle.
  - Entry from IDLE leaves the prescaler at 0, so the first tick occurs PRESCALE cycles after the START edge.
- Count advance on tick, effective at the same edge and visible next cycle:
  - Packed BCD increment with digit carries: 0x0009→0x0010, 0x0099→0x0100, 0x0999→0x1000.
  - 0x9999→0x0000 wrap when the limit is not hit.
- Limit:
  - If limit_en and the next count equals limit at a tick edge: count←limit and state←DONE.
  - limit=0x0000 with limit_en is hit on the 9999→0000 wrap.
  - A limit containing a nibble >9 never matches.
  - limit and limit_en are sampled only on tick cycles.
- Simultaneous events in RUN:
  - tick+STOP: the increment is applied, then PAUSE.
  - tick+CLEAR: CLEAR wins; no increment.
  - tick+LAP: lap gets the pre-increment count.
  - tick+limit hit: DONE is entered with count=limit.
- running = (state==RUN); done = (state==DONE). Both are registered-state decodes with no extra latency.

Decomposition:
- Package bcd_timer_pkg:
  - cmd_op_e enum (CMD_START, CMD_STOP, CMD_CLEAR, CMD_LAP).
  - state_e enum (S_IDLE, S_RUN, S_PAUSE, S_DONE, S_CLR).
  - BCD_W=16, NDIGITS=4.
  - Function bcd_inc(16b)→16b.
- One sub-module, bcd4_counter: async active-low reset, synchronous clr, inc strobe, 16-bit count out. The controller drives clr/inc and does the limit compare on the sub-module's next-value output.

Test Plan:
- Reset with PRESCALE=4: assert rst_n=0 mid-RUN at count=0x0003 → all outputs 0 at once, cmd_ready=1; after release, state is IDLE and 20 cycles with no command leave count=0x0000.
- START, run 40 cycles (PRESCALE=4) → tick every 4th cycle, first tick 4 cycles after START, count=0x0010 after 10 ticks, running=1.
- PRESCALE=1, START, run 10000 cycles → count passes 0x0099→0x0100 and 0x0999→0x1000, then 0x9999→0x0000 on tick 10000, done=0.
- limit_en=1, limit=0x0025, START (PRESCALE=4) → done=1 and running=0 at tick 25; count holds 0x0025 for 100 further cycles; START ignored; CLEAR → cmd_ready=0 for one cycle, then count=0, done=0, IDLE.
- STOP with prescaler=2 at count=0x0007, wait 50 cycles, then START → count stays 0x0007 throughout the pause; the next tick comes 2 cycles after START (prescaler counts 2,3, ticks at 3); count=0x0008.
- In the tick cycle where count=0x0019, issue LAP → lap=0x0019, lap_valid high exactly the next cycle, count=0x0020. Separately, issue CLEAR in a tick cycle → count=0x0000, no increment.
